// File: rtl/npc_pc_unit.sv
// ----------------------------------------------------------------------------
// npc_pc_unit
//  Next-PC generation and PC register for the 5-stage MIPS pipeline.
//  Branches and jumps resolve in ID with one architectural delay slot, so a
//  redirect only changes the next fetch address and no instruction is flushed.
//  Saturating branch statistics counters are kept for performance debug.
//
//  Ports
//   i_clk          clock, all state updates on rising edge
//   i_reset        synchronous reset, active-low (0 = reset)
//   i_stall        hazard-unit stall, holds PC and statistics counters
//   i_br_type      ID decode: 0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz,
//                  6 bgez, 7 j, 8 jal, 9 jr, 10 jalr, 11..15 none
//   i_isbeq..i_isbgez  comparator flags for the ID instruction
//   i_pc_id        PC of the instruction in ID
//   i_imm16        ID instr[15:0]
//   i_idx26        ID instr[25:0]
//   i_rs_val       forwarded rs value (jr/jalr target)
//   o_pc_if        PC register, the fetch address
//   o_npc          combinational next PC
//   o_br_taken     ID branch/jump redirects this cycle
//   o_link_addr    pc_id + 8, return address for jal/jalr
//   o_addr_err     next PC is not word aligned
//   o_fetch_valid  low while in BOOT
//   o_br_cnt       conditional branches retired from ID (saturating)
//   o_taken_cnt    conditional branches taken (saturating)
// ----------------------------------------------------------------------------
module npc_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic [3:0]       i_br_type,
    input  logic             i_isbeq,
    input  logic             i_isbne,
    input  logic             i_isblez,
    input  logic             i_isbgtz,
    input  logic             i_isbltz,
    input  logic             i_isbgez,
    input  logic [31:0]      i_pc_id,
    input  logic [15:0]      i_imm16,
    input  logic [25:0]      i_idx26,
    input  logic [31:0]      i_rs_val,
    output logic [31:0]      o_pc_if,
    output logic [31:0]      o_npc,
    output logic             o_br_taken,
    output logic [31:0]      o_link_addr,
    output logic             o_addr_err,
    output logic             o_fetch_valid,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_taken_cnt
);

    localparam int unsigned PC_W = 32;

    localparam logic [3:0] BT_BEQ  = 4'd1;
    localparam logic [3:0] BT_BNE  = 4'd2;
    localparam logic [3:0] BT_BLEZ = 4'd3;
    localparam logic [3:0] BT_BGTZ = 4'd4;
    localparam logic [3:0] BT_BLTZ = 4'd5;
    localparam logic [3:0] BT_BGEZ = 4'd6;
    localparam logic [3:0] BT_J    = 4'd7;
    localparam logic [3:0] BT_JAL  = 4'd8;
    localparam logic [3:0] BT_JR   = 4'd9;
    localparam logic [3:0] BT_JALR = 4'd10;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [PC_W-1:0]    r_pc_if;
    logic [PC_W-1:0]    w_pc_next;
    logic [CNT_W-1:0]   r_br_cnt;
    logic [CNT_W-1:0]   r_taken_cnt;
    logic [CNT_W-1:0]   w_br_cnt_next;
    logic [CNT_W-1:0]   w_taken_cnt_next;

    logic [PC_W-1:0]    w_pc_id_p4;
    logic [PC_W-1:0]    w_br_off;
    logic [PC_W-1:0]    w_br_target;
    logic [PC_W-1:0]    w_j_target;
    logic [PC_W-1:0]    w_seq_pc;
    logic [PC_W-1:0]    w_jump_target;
    logic [PC_W-1:0]    w_npc;
    logic               w_is_cond;
    logic               w_cond_true;
    logic               w_is_jump;
    logic               w_br_taken;
    logic               w_fetch_valid;
    logic               w_advance;
    logic               w_br_cnt_sat;
    logic               w_taken_cnt_sat;

    // Target address arithmetic, all modulo 2^32.
    assign w_pc_id_p4  = i_pc_id + PC_W'(4);
    assign w_br_off    = {{14{i_imm16[15]}}, i_imm16, 2'b00};
    assign w_br_target = w_pc_id_p4 + w_br_off;
    // Region bits come from the delay-slot PC so a carry out of bit 27 is honoured.
    assign w_j_target  = {w_pc_id_p4[31:28], i_idx26, 2'b00};
    assign w_seq_pc    = r_pc_if + PC_W'(4);

    // Branch/jump type decode and condition select.
    always_comb begin
        w_is_cond     = 1'b0;
        w_cond_true   = 1'b0;
        w_is_jump     = 1'b0;
        w_jump_target = w_j_target;
        case (i_br_type)
            BT_BEQ: begin
                w_is_cond   = 1'b1;
                w_cond_true = i_isbeq;
            end
            BT_BNE: begin
                w_is_cond   = 1'b1;
                w_cond_true = i_isbne;
            end
            BT_BLEZ: begin
                w_is_cond   = 1'b1;
                w_cond_true = i_isblez;
            end
            BT_BGTZ: begin
                w_is_cond   = 1'b1;
                w_cond_true = i_isbgtz;
            end
            BT_BLTZ: begin
                w_is_cond   = 1'b1;
                w_cond_true = i_isbltz;
            end
            BT_BGEZ: begin
                w_is_cond   = 1'b1;
                w_cond_true = i_isbgez;
            end
            BT_J, BT_JAL: begin
                w_is_jump     = 1'b1;
                w_jump_target = w_j_target;
            end
            BT_JR, BT_JALR: begin
                w_is_jump     = 1'b1;
                w_jump_target = i_rs_val;
            end
            default: begin
                w_is_cond = 1'b0;
                w_is_jump = 1'b0;
            end
        endcase
    end

    // No redirect can happen while the pipeline is still booting.
    assign w_br_taken = (r_state != ST_BOOT) && (w_is_jump || (w_is_cond && w_cond_true));

    always_comb begin
        w_npc = w_seq_pc;
        if (w_br_taken) begin
            w_npc = w_is_jump ? w_jump_target : w_br_target;
        end
    end

    // A branch held in ID by a stall is only committed on the cycle it is released.
    assign w_advance = (r_state != ST_BOOT) && !i_stall;

    // FSM next state and PC update.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc_if;
        w_fetch_valid = 1'b1;
        case (r_state)
            ST_BOOT: begin
                w_fetch_valid = 1'b0;
                w_state_next  = ST_RUN;
            end
            ST_RUN: begin
                if (i_stall) begin
                    w_state_next = ST_HOLD;
                end else begin
                    w_pc_next = w_npc;
                end
            end
            ST_HOLD: begin
                if (!i_stall) begin
                    w_pc_next    = w_npc;
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_fetch_valid = 1'b0;
                w_state_next  = ST_BOOT;
            end
        endcase
    end

    // Saturating statistics counters.
    assign w_br_cnt_sat    = (r_br_cnt == {CNT_W{1'b1}});
    assign w_taken_cnt_sat = (r_taken_cnt == {CNT_W{1'b1}});

    always_comb begin
        w_br_cnt_next    = r_br_cnt;
        w_taken_cnt_next = r_taken_cnt;
        if (w_advance && w_is_cond) begin
            if (!w_br_cnt_sat) begin
                w_br_cnt_next = r_br_cnt + CNT_W'(1);
            end
            if (w_cond_true && !w_taken_cnt_sat) begin
                w_taken_cnt_next = r_taken_cnt + CNT_W'(1);
            end
        end
    end

    // State, PC and counter registers; reset dominates every other input.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= ST_BOOT;
            r_pc_if     <= RESET_PC;
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pc_if     <= w_pc_next;
            r_br_cnt    <= w_br_cnt_next;
            r_taken_cnt <= w_taken_cnt_next;
        end
    end

    assign o_pc_if       = r_pc_if;
    assign o_npc         = w_npc;
    assign o_br_taken    = w_br_taken;
    assign o_link_addr   = i_pc_id + PC_W'(8);
    assign o_addr_err    = (w_npc[1:0] != 2'b00);
    assign o_fetch_valid = w_fetch_valid;
    assign o_br_cnt      = r_br_cnt;
    assign o_taken_cnt   = r_taken_cnt;

endmodule
